param_register_block: RTL and testbench

//  Parametrised slow-control register file between the Master FPGA link and channel logic.

---
 rtl/param_register_block.sv | 148 ++++++++++++++
 tb/tb_param_register_block.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_register_block.sv
// param_register_block: parametrised slow-control register file.
// N_REGS = 2**ADDR_W registers of DATA_W bits. Registers whose RO_MASK bit is
// set read back the matching ro_data slice and reject writes. Rejected
// accesses bump a saturating error counter.
// Optional feature macro: REGBLK_AUTOINC_EN (auto-increment the register index
// after every access cycle, for burst transfers).
module param_register_block #(
  parameter int                         DATA_W  = 32,
  parameter int                         ADDR_W  = 5,
  parameter logic [(2**ADDR_W)-1:0]     RO_MASK = '0,
  parameter int                         ERR_W   = 16
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [DATA_W-1:0]                rx_data,
  input  logic                             reg_num_le,
  input  logic                             wr_en,
  input  logic                             rd_en,
  output logic [DATA_W-1:0]                tx_data,
  output logic                             rd_valid,
  output logic                             illegal_reg_num,
  output logic [ERR_W-1:0]                 err_cnt,
  output logic [(2**ADDR_W)*DATA_W-1:0]    reg_q,
  input  logic [(2**ADDR_W)*DATA_W-1:0]    ro_data,
  output logic [(2**ADDR_W)-1:0]           wr_strobe,
  output logic [(2**ADDR_W)-1:0]           rd_strobe
);

  localparam int N_REGS = 2**ADDR_W;

  // Read handshake: rd_en is a single-cycle request with no back-pressure.
  // Exactly one cycle later rd_valid is high for one cycle and tx_data holds
  // the word sampled at the rd_en edge; back-to-back requests keep rd_valid
  // high with a new word every cycle. tx_data holds between reads.

  // State
  logic [DATA_W-1:0]              reg_num_q, reg_num_d;
  logic [N_REGS-1:0][DATA_W-1:0]  regs_q, regs_d;
  logic [DATA_W-1:0]              tx_data_q, tx_data_d;
  logic                           rd_valid_q, rd_valid_d;
  logic [ERR_W-1:0]               err_cnt_q, err_cnt_d;
  logic [N_REGS-1:0]              wr_strobe_q, wr_strobe_d;
  logic [N_REGS-1:0]              rd_strobe_q, rd_strobe_d;

  // Decode of the current register number
  logic [ADDR_W-1:0]              idx;
  logic                           illegal;
  logic                           idx_ro;
  logic [DATA_W-1:0]              rd_word;
  logic                           wr_ok;
  logic                           access_err;
  logic [N_REGS-1:0]              idx_onehot;

  // Address decode, read mux and access legality
  always_comb begin
    idx        = reg_num_q[ADDR_W-1:0];
    illegal    = |reg_num_q[DATA_W-1:ADDR_W];
    idx_ro     = RO_MASK[idx];
    idx_onehot = N_REGS'(1) << idx;
    rd_word    = '0;
    if (!illegal) begin
      if (idx_ro) begin
        rd_word = ro_data[idx*DATA_W +: DATA_W];
      end else begin
        rd_word = regs_q[idx];
      end
    end
    wr_ok      = wr_en && !illegal && !idx_ro;
    // A cycle with both wr and rd rejected still counts as one error.
    access_err = (wr_en && !wr_ok) || (rd_en && illegal);
  end

  // Register array update and write strobes
  always_comb begin
    regs_d      = regs_q;
    wr_strobe_d = '0;
    if (wr_ok) begin
      regs_d[idx] = rx_data;
      wr_strobe_d = idx_onehot;
    end
  end

  // Registered read path; the mux uses pre-write contents so a same-cycle
  // write to the read index returns the old value
  always_comb begin
    tx_data_d   = tx_data_q;
    rd_valid_d  = rd_en;
    rd_strobe_d = '0;
    if (rd_en) begin
      tx_data_d = rd_word;
      if (!illegal) begin
        rd_strobe_d = idx_onehot;
      end
    end
  end

  // Saturating error counter
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (access_err && !(&err_cnt_q)) begin
      err_cnt_d = err_cnt_q + ERR_W'(1);
    end
  end

  // Register-number update: an explicit load always wins
  always_comb begin
    reg_num_d = reg_num_q;
    if (reg_num_le) begin
      reg_num_d = rx_data;
    end
`ifdef REGBLK_AUTOINC_EN
    else if (wr_en || rd_en) begin
      // Only the index field wraps; upper bits (and hence legality) persist.
      reg_num_d = {reg_num_q[DATA_W-1:ADDR_W], idx + ADDR_W'(1)};
    end
`endif
  end

  // All state flops, asynchronously cleared
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      reg_num_q   <= '0;
      regs_q      <= '0;
      tx_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      err_cnt_q   <= '0;
      wr_strobe_q <= '0;
      rd_strobe_q <= '0;
    end else begin
      reg_num_q   <= reg_num_d;
      regs_q      <= regs_d;
      tx_data_q   <= tx_data_d;
      rd_valid_q  <= rd_valid_d;
      err_cnt_q   <= err_cnt_d;
      wr_strobe_q <= wr_strobe_d;
      rd_strobe_q <= rd_strobe_d;
    end
  end

  assign tx_data         = tx_data_q;
  assign rd_valid        = rd_valid_q;
  assign illegal_reg_num = illegal;
  assign err_cnt         = err_cnt_q;
  assign reg_q           = regs_q;
  assign wr_strobe       = wr_strobe_q;
  assign rd_strobe       = rd_strobe_q;

endmodule

// File: tb/tb_param_register_block.sv
// Bench for param_register_block (DATA_W=32, ADDR_W=5, RO regs 1 and 9).
// Build with or without +define+REGBLK_AUTOINC_EN; the reference model follows.
module tb_param_register_block;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int N_REGS = 32;
  localparam int ERR_W  = 16;
  localparam logic [N_REGS-1:0] RO_MASK = 32'h0000_0202;

  // Clock / reset
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic [DATA_W-1:0]        rx_data;
  logic                     reg_num_le, wr_en, rd_en;
  logic [DATA_W-1:0]        tx_data;
  logic                     rd_valid, illegal_reg_num;
  logic [ERR_W-1:0]         err_cnt;
  logic [N_REGS*DATA_W-1:0] reg_q, ro_data;
  logic [N_REGS-1:0]        wr_strobe, rd_strobe;

  param_register_block #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .RO_MASK(RO_MASK),
    .ERR_W  (ERR_W)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .rx_data        (rx_data),
    .reg_num_le     (reg_num_le),
    .wr_en          (wr_en),
    .rd_en          (rd_en),
    .tx_data        (tx_data),
    .rd_valid       (rd_valid),
    .illegal_reg_num(illegal_reg_num),
    .err_cnt        (err_cnt),
    .reg_q          (reg_q),
    .ro_data        (ro_data),
    .wr_strobe      (wr_strobe),
    .rd_strobe      (rd_strobe)
  );

  int total = 0;
  int bad   = 0;
  bit started = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain arrays and integers, updated once per clock edge
  logic [DATA_W-1:0] m_regs [N_REGS];
  logic [DATA_W-1:0] m_reg_num = '0;
  logic [DATA_W-1:0] m_tx = '0;
  bit                m_valid = 1'b0;
  int                m_err = 0;
  logic [N_REGS-1:0] m_wr_stb = '0;
  logic [N_REGS-1:0] m_rd_stb = '0;
  logic [DATA_W-1:0] exp_q [$];
  int                m_idx;
  bit                m_illegal;
  logic [DATA_W-1:0] m_word;

  initial for (int i = 0; i < N_REGS; i++) m_regs[i] = '0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_REGS; i++) m_regs[i] = '0;
      m_reg_num = '0; m_tx = '0; m_valid = 0; m_err = 0;
      m_wr_stb = '0; m_rd_stb = '0;
      exp_q.delete();
    end else begin
      m_idx     = int'(m_reg_num % N_REGS);
      m_illegal = (m_reg_num / N_REGS) != 0;
      m_wr_stb  = '0;
      m_rd_stb  = '0;
      m_valid   = rd_en;
      // read first: same-cycle write must not be visible
      if (rd_en) begin
        if (m_illegal) m_word = '0;
        else if (RO_MASK[m_idx]) m_word = ro_data[m_idx*DATA_W +: DATA_W];
        else m_word = m_regs[m_idx];
        m_tx = m_word;
        exp_q.push_back(m_word);
        if (!m_illegal) m_rd_stb[m_idx] = 1'b1;
      end
      if (wr_en && !m_illegal && !RO_MASK[m_idx]) begin
        m_regs[m_idx] = rx_data;
        m_wr_stb[m_idx] = 1'b1;
      end
      if ((wr_en && (m_illegal || RO_MASK[m_idx])) || (rd_en && m_illegal))
        if (m_err < 65535) m_err = m_err + 1;
      if (reg_num_le) m_reg_num = rx_data;
`ifdef REGBLK_AUTOINC_EN
      else if (wr_en || rd_en)
        m_reg_num = (m_reg_num / N_REGS) * N_REGS + DATA_W'((m_idx + 1) % N_REGS);
`endif
    end
  end

  // Scoreboard / compare: every falling edge once out of initial reset
  always @(negedge clk) begin
    if (started) begin
      check("tx_data", tx_data, m_tx);
      check("rd_valid", rd_valid, m_valid);
      check("rd_strobe", rd_strobe, m_rd_stb);
      check("wr_strobe", wr_strobe, m_wr_stb);
      check("err_cnt", err_cnt, m_err[ERR_W-1:0]);
      check("illegal", illegal_reg_num, (m_reg_num / N_REGS) != 0);
      for (int i = 0; i < N_REGS; i++)
        check("reg_q", reg_q[i*DATA_W +: DATA_W], m_regs[i]);
      if (rd_valid) begin
        if (exp_q.size() == 0) check("rd_q_empty", 1, 0);
        else check("rd_q_word", tx_data, exp_q.pop_front());
      end else if (exp_q.size() != 0) begin
        exp_q.delete();
      end
    end
  end

  // Driver: called at a falling edge, applies one cycle of inputs
  task automatic drive(input logic le, input logic wr, input logic rd, input logic [DATA_W-1:0] d);
    reg_num_le = le; wr_en = wr; rd_en = rd; rx_data = d;
    @(negedge clk);
    reg_num_le = 0; wr_en = 0; rd_en = 0;
  endtask

  function automatic logic [DATA_W-1:0] slice(input int i);
    return reg_q[i*DATA_W +: DATA_W];
  endfunction

  initial begin
    reset_n = 0; reg_num_le = 0; wr_en = 0; rd_en = 0; rx_data = '0;
    for (int i = 0; i < N_REGS; i++) ro_data[i*DATA_W +: DATA_W] = $urandom;
    ro_data[1*DATA_W +: DATA_W] = 32'h0000_1234;
    ro_data[9*DATA_W +: DATA_W] = 32'hCAFE_0009;
    repeat (3) @(negedge clk);
    reset_n = 1;
    started = 1;
    @(negedge clk);
    check("rst_tx", tx_data, 0);
    check("rst_err", err_cnt, 0);
    check("rst_regs_any", |reg_q, 0);

    // 1: read every index after reset
    for (int i = 0; i < N_REGS; i++) begin
      drive(1, 0, 0, i);
      drive(0, 0, 1, 0);
      check("t1_valid", rd_valid, 1);
      if (i == 1) check("t1_ro1", tx_data, 32'h0000_1234);
      else if (i == 9) check("t1_ro9", tx_data, 32'hCAFE_0009);
      else check("t1_rw0", tx_data, 0);
      drive(0, 0, 0, 0);
      check("t1_valid_drop", rd_valid, 0);
    end

    // 2: write then read reg 3
    drive(1, 0, 0, 3);
    drive(0, 1, 0, 32'hA5A5_0003);
    check("t2_slice3", slice(3), 32'hA5A5_0003);
    check("t2_wstb", wr_strobe, 32'h0000_0008);
    drive(0, 0, 0, 0);
    check("t2_wstb_drop", wr_strobe, 0);
    drive(1, 0, 0, 3);
    drive(0, 0, 1, 0);
    check("t2_tx", tx_data, 32'hA5A5_0003);

    // 3: write to read-only reg 1 is rejected
    drive(1, 0, 0, 1);
    drive(0, 1, 0, 32'h0000_FFFF);
    check("t3_slice1", slice(1), 0);
    check("t3_err", err_cnt, 1);
    check("t3_wstb", wr_strobe, 0);
    drive(1, 0, 0, 1);
    drive(0, 0, 1, 0);
    check("t3_tx", tx_data, 32'h0000_1234);
    check("t3_rstb", rd_strobe, 32'h0000_0002);

    // 4: illegal register number
    drive(1, 0, 0, 32'h0000_0020);
    check("t4_illegal", illegal_reg_num, 1);
    drive(0, 1, 0, 32'h1111_1111);
    drive(0, 0, 1, 0);
    check("t4_tx", tx_data, 0);
    check("t4_valid", rd_valid, 1);
    check("t4_rstb", rd_strobe, 0);
    check("t4_err", err_cnt, 3);
    check("t4_slice0", slice(0), 0);

    // 5: burst of three writes starting at reg 30
    drive(1, 0, 0, 30);
    drive(0, 1, 0, 32'h0000_0030);
    drive(0, 1, 0, 32'h0000_0031);
    drive(0, 1, 0, 32'h0000_0032);
    drive(0, 0, 1, 0);
`ifdef REGBLK_AUTOINC_EN
    check("t5_s30", slice(30), 32'h30);
    check("t5_s31", slice(31), 32'h31);
    check("t5_s0", slice(0), 32'h32);
    check("t5_rd_reg1", tx_data, 32'h0000_1234);
`else
    check("t5_s30", slice(30), 32'h32);
    check("t5_s31", slice(31), 0);
    check("t5_s0", slice(0), 0);
    check("t5_rd_reg30", tx_data, 32'h32);
`endif

    // same-cycle write and read of reg 5 returns the old value
    drive(1, 0, 0, 5);
    drive(0, 1, 1, 32'hDEAD_0005);
    check("wr_rd_tx_old", tx_data, 0);
    check("wr_rd_slice5", slice(5), 32'hDEAD_0005);
    check("wr_rd_rstb", rd_strobe, 32'h0000_0020);
    check("wr_rd_wstb", wr_strobe, 32'h0000_0020);

    // same-cycle load and write: write uses the old index 6
    drive(1, 0, 0, 6);
    drive(1, 1, 0, 7);
    check("le_wr_slice6", slice(6), 7);
    check("le_wr_slice7", slice(7), 0);
    drive(0, 0, 1, 0);
    check("le_wr_rstb7", rd_strobe, 32'h0000_0080);

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      logic le, wr, rd;
      logic [DATA_W-1:0] d;
      le = ($urandom_range(0, 5) == 0);
      wr = ($urandom_range(0, 1) == 1);
      rd = ($urandom_range(0, 1) == 1);
      if (le && !wr) d = ($urandom_range(0, 9) == 0) ? DATA_W'($urandom) : DATA_W'($urandom_range(0, 31));
      else d = $urandom;
      drive(le, wr, rd, d);
    end

    // 6a: saturate the error counter with illegal writes
    drive(1, 0, 0, 32'h0000_0040);
    for (int n = 0; n < 65540; n++) begin
      reg_num_le = 0; wr_en = 1; rd_en = 0; rx_data = $urandom;
      @(negedge clk);
    end
    wr_en = 0;
    @(negedge clk);
    check("sat_err", err_cnt, 16'hFFFF);

    // 6b: asynchronous reset in the middle of a read
    drive(1, 0, 0, 3);
    drive(0, 1, 0, 32'h5A5A_0303);
    rd_en = 1;
    @(posedge clk);
    #2;
    reset_n = 0;
    rd_en = 0;
    #1;
    check("arst_tx", tx_data, 0);
    check("arst_valid", rd_valid, 0);
    check("arst_err", err_cnt, 0);
    check("arst_regs_any", |reg_q, 0);
    check("arst_rstb", rd_strobe, 0);
    check("arst_wstb", wr_strobe, 0);
    @(negedge clk);
    reset_n = 1;
    @(negedge clk);
    drive(1, 0, 0, 3);
    drive(0, 0, 1, 0);
    check("post_rst_tx", tx_data, 0);
    check("post_rst_valid", rd_valid, 1);
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
